// File: rtl/seq_display_player.sv
// Sequence player: steps through a small writable value table at a divided tick rate
// (wrap or ping-pong traversal) and shows the current value on two 7-segment digits.
module seq_display_player #(
    parameter int FPGA_F  = 50_000_000,
    parameter int TICK_HZ = 2,
    parameter int W       = 4,
    parameter int DEPTH   = 8,
    localparam int AW     = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up,
    input  logic          mode,
    input  logic [1:0]    rate,
    input  logic          restart,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    output logic          tick,
    output logic          step,
    output logic [AW-1:0] pos,
    output logic [W-1:0]  value,
    output logic [6:0]    seg1,
    output logic [6:0]    seg0
);

    localparam int DIV = FPGA_F / TICK_HZ;
    localparam int CW  = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [AW-1:0] POS_LAST = AW'(DEPTH - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sub;
    logic [AW-1:0] r_pos;
    logic          r_dir;
    logic          r_pp;
    logic [W-1:0]  r_mem [DEPTH];

    logic          w_tick;
    logic [1:0]    w_mask;
    logic          w_step_raw;
    logic          w_dir;
    logic          w_dir_nxt;
    logic [AW-1:0] w_pos_nxt;
    logic          w_wr_ok;
    logic [6:0]    w_val7;
    logic [3:0]    w_units;
    logic [3:0]    w_tens;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_mask = 2'b00;
        case (rate)
            2'b01:   w_mask = 2'b01;
            2'b10:   w_mask = 2'b11;
            default: w_mask = 2'b00;
        endcase
    end

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_step_raw = w_tick && (rate != 2'b11) && ((r_sub & w_mask) == w_mask);
    assign w_wr_ok    = wr_en && (int'(wr_addr) < DEPTH);
    // The first ping-pong cycle takes its direction straight from up.
    assign w_dir      = (mode && r_pp) ? r_dir : up;

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = w_dir;
        if (w_step_raw) begin
            if (!mode) begin
                if (w_dir) w_pos_nxt = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
                else       w_pos_nxt = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;
            end else if (w_dir) begin
                if (r_pos == POS_LAST) begin
                    w_pos_nxt = r_pos - 1'b1;
                    w_dir_nxt = 1'b0;
                end else begin
                    w_pos_nxt = r_pos + 1'b1;
                end
            end else begin
                if (r_pos == '0) begin
                    w_pos_nxt = AW'(1);
                    w_dir_nxt = 1'b1;
                end else begin
                    w_pos_nxt = r_pos - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_sub <= '0;
            r_pos <= '0;
            r_dir <= 1'b1;
            r_pp  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= W'(5 * (i + 1));
            end
        end else begin
            r_pp <= mode;
            if (w_wr_ok) r_mem[wr_addr] <= wr_data;
            if (restart) begin
                r_cnt <= '0;
                r_sub <= '0;
                r_pos <= '0;
                r_dir <= up;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                if (w_tick && (rate != 2'b11)) r_sub <= r_sub + 1'b1;
                r_pos <= w_pos_nxt;
                r_dir <= w_dir_nxt;
            end
        end
    end

    assign w_val7  = 7'(value);
    assign w_units = 4'(w_val7 % 7'd10);
    assign w_tens  = 4'(w_val7 / 7'd10);

    assign tick  = w_tick;
    assign step  = w_step_raw && !restart && !reset;
    assign pos   = r_pos;
    assign value = r_mem[r_pos];
    assign seg0  = seg7(w_units);
    assign seg1  = (w_val7 < 7'd10) ? 7'h7F : seg7(w_tens);

endmodule

// File: tb/tb_seq_display_player.sv
// Bench for seq_display_player: directed phases followed by random traffic, all
// checked against a table/phase-index model of the player.
module tb_seq_display_player;

    localparam int DIV = 4;
    localparam int D   = 6;
    localparam int PER = 2 * D - 2;

    logic       clk = 1'b0;
    logic       reset, up, mode, restart, wr_en;
    logic [1:0] rate;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic       d_tick, d_step;
    logic [2:0] d_pos;
    logic [5:0] d_value;
    logic [6:0] d_seg1, d_seg0;

    seq_display_player #(.FPGA_F(8), .TICK_HZ(2), .W(6), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .up(up), .mode(mode), .rate(rate),
        .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tick(d_tick), .step(d_step), .pos(d_pos), .value(d_value),
        .seg1(d_seg1), .seg0(d_seg0)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_cnt, m_sub, m_pos, m_k;
    bit m_inpp;
    int m_mem [D];
    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int kpos(input int k);
        return (k < D) ? k : PER - k;
    endfunction

    function automatic int cur_pos();
        return m_inpp ? kpos(m_k) : m_pos;
    endfunction

    function automatic bit will_step();
        int per;
        per = 1 << rate;
        return (m_cnt == DIV - 1) && (rate != 2'b11) && ((m_sub % per) == per - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit do_chk);
        int p, v, per;
        bit tick_e, raw, step_e;
        @(negedge clk);
        if (mode && !m_inpp) begin
            m_k    = up ? m_pos : (PER - m_pos) % PER;
            m_inpp = 1'b1;
        end else if (!mode && m_inpp) begin
            m_pos  = kpos(m_k);
            m_inpp = 1'b0;
        end
        p      = cur_pos();
        v      = m_mem[p];
        per    = 1 << rate;
        tick_e = (m_cnt == DIV - 1);
        raw    = tick_e && (rate != 2'b11) && ((m_sub % per) == per - 1);
        step_e = raw && !restart && !reset;
        if (do_chk) begin
            chk("tick", 32'(d_tick), 32'(tick_e));
            chk("step", 32'(d_step), 32'(step_e));
            chk("pos", 32'(d_pos), 32'(p));
            chk("value", 32'(d_value), 32'(v));
            chk("seg0", 32'(d_seg0), 32'(seg_tbl[v % 10]));
            chk("seg1", 32'(d_seg1), (v < 10) ? 32'h7F : 32'(seg_tbl[v / 10]));
        end
        if (reset) begin
            m_cnt = 0; m_sub = 0; m_pos = 0; m_k = 0; m_inpp = 1'b0;
            for (int i = 0; i < D; i++) m_mem[i] = (5 * (i + 1)) % 64;
        end else begin
            if (wr_en && (int'(wr_addr) < D)) m_mem[wr_addr] = int'(wr_data);
            if (restart) begin
                m_cnt = 0; m_sub = 0; m_pos = 0; m_k = 0;
            end else begin
                if (raw) begin
                    if (m_inpp) m_k = (m_k + 1) % PER;
                    else        m_pos = up ? (m_pos + 1) % D : (m_pos + D - 1) % D;
                end
                if (tick_e && rate != 2'b11) m_sub = (m_sub + 1) % 4;
                m_cnt = (m_cnt + 1) % DIV;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1);
    endtask

    initial begin
        bit found;
        reset = 1'b1; up = 1'b1; mode = 1'b0; rate = 2'b00; restart = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        m_cnt = 0; m_sub = 0; m_pos = 0; m_k = 0; m_inpp = 1'b0;
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        cycle(1'b0);
        cycle(1'b0);
        reset = 1'b0;

        chk("rst_value", 32'(d_value), 32'd5);
        chk("rst_seg0", 32'(d_seg0), 32'h12);
        chk("rst_seg1", 32'(d_seg1), 32'h7F);
        chk("rst_tick", 32'(d_tick), 32'd0);
        chk("rst_step", 32'(d_step), 32'd0);
        chk("rst_pos", 32'(d_pos), 32'd0);

        run(40);                          // wrap upward past the end

        restart = 1'b1; up = 1'b0;
        cycle(1'b1);
        restart = 1'b0;
        run(40);                          // wrap downward from 0

        restart = 1'b1; mode = 1'b1; up = 1'b1;
        cycle(1'b1);
        restart = 1'b0;
        run(70);                          // ping-pong bounces at both ends

        rate = 2'b10;  run(50);
        rate = 2'b11;  run(20);
        rate = 2'b10;  run(50);
        rate = 2'b01;  run(30);

        rate = 2'b11;
        run(2);
        wr_en = 1'b1; wr_addr = 3'(cur_pos()); wr_data = 6'd42;
        cycle(1'b1);
        wr_en = 1'b0;
        chk("wr_value", 32'(d_value), 32'd42);
        chk("wr_seg1", 32'(d_seg1), 32'h19);
        chk("wr_seg0", 32'(d_seg0), 32'h24);
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 6'd1;
        cycle(1'b1);
        wr_addr = 3'd7;
        cycle(1'b1);
        wr_en = 1'b0;
        mode = 1'b0; up = 1'b1; rate = 2'b00;
        run(30);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (will_step()) found = 1'b1;
            else cycle(1'b1);
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL restart_wait observed=timeout expected=step");
        end
        restart = 1'b1;
        cycle(1'b1);
        restart = 1'b0;
        chk("restart_pos", 32'(d_pos), 32'd0);
        chk("restart_value", 32'(d_value), 32'(m_mem[0]));
        run(10);

        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (will_step()) found = 1'b1;
            else cycle(1'b1);
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("FAIL reset_wait observed=timeout expected=step");
        end
        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
        chk("reset_pos", 32'(d_pos), 32'd0);
        chk("reset_value", 32'(d_value), 32'd5);

        for (int i = 0; i < 900; i++) begin
            up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) rate = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 31) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 6'($urandom_range(0, 63));
            cycle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
